// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the lab6 datapath controller.
// HALT exists only when CTRL_ILLEGAL_TRAP_EN is defined.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    WAIT,
    DECODE,
    WRIMM,
    GETA,
    GETB,
    EXEC,
    STAT,
    WRREG
`ifdef CTRL_ILLEGAL_TRAP_EN
    , HALT
`endif
  } state_t;

  localparam logic [1:0] NSEL_RN = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RM = 2'b10;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM8  = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [4:0] MOV_IMM = 5'b110_10;
  localparam logic [4:0] MOV_REG = 5'b110_00;
  localparam logic [4:0] ADD     = 5'b101_00;
  localparam logic [4:0] CMP     = 5'b101_01;
  localparam logic [4:0] AND     = 5'b101_10;
  localparam logic [4:0] MVN     = 5'b101_11;

endpackage

// File: rtl/cpu_controller.sv
// Moore sequencer for the lab6 datapath, one instruction per s pulse.
// CTRL_ILLEGAL_TRAP_EN: illegal opcodes lock into HALT with err=1.
module cpu_controller
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       err
);

  state_t     state, nxt;
  logic [4:0] ins_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT;
      ins_q <= '0;
    end else begin
      state <= nxt;
      if (state == WAIT && s)
        ins_q <= {opcode, op};
    end
  end

  always_comb begin
    nxt   = state;
    w     = 1'b0;
    nsel  = NSEL_RN;
    vsel  = VSEL_C;
    write = 1'b0;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    err   = 1'b0;
    unique case (state)
      WAIT: begin
        w = 1'b1;
        if (s) nxt = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          (ins_q == MOV_IMM): nxt = WRIMM;
          (ins_q == MOV_REG),
          (ins_q == MVN):     nxt = GETB;
          (ins_q == ADD),
          (ins_q == CMP),
          (ins_q == AND):     nxt = GETA;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:            nxt = HALT;
`else
          default:            nxt = WAIT;
`endif
        endcase
      end
      WRIMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM8;
        write = 1'b1;
        nxt   = WAIT;
      end
      GETA: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
        nxt   = GETB;
      end
      GETB: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
        nxt   = (ins_q == CMP) ? STAT : EXEC;
      end
      EXEC: begin
        loadc = 1'b1;
        // single-operand ops pass B through with A zeroed
        asel  = (ins_q == MOV_REG) || (ins_q == MVN);
        nxt   = WRREG;
      end
      STAT: begin
        loads = 1'b1;
        nxt   = WAIT;
      end
      WRREG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
        nxt   = WAIT;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      HALT: begin
        err = 1'b1;
        nxt = HALT;
      end
`endif
      default: nxt = WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: per-instruction output schedule model.
// Honours CTRL_ILLEGAL_TRAP_EN the same way as the design.
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w, write, loada, loadb, loadc, loads, asel, bsel, err;
  logic [1:0] nsel, vsel;

  int checks = 0;
  int errors = 0;
  int lat;
  int cnt;

  cpu_controller dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .vsel(vsel), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .err(err)
  );

  always #5 clk = ~clk;

  // {w,nsel,vsel,write,loada,loadb,loadc,loads,asel,bsel,err}
  function automatic logic [13:0] ov(
    input logic w_, input logic [1:0] ns, input logic [1:0] vs,
    input logic wr, input logic la, input logic lb, input logic lc,
    input logic ls, input logic as_, input logic bs, input logic er);
    return {w_, ns, vs, wr, la, lb, lc, ls, as_, bs, er};
  endfunction

  logic [13:0] q[$];
  bit          halted;

  task automatic start(input logic [4:0] ins);
    q.push_back(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    case (ins)
      5'b110_10: q.push_back(ov(0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0));
      5'b110_00, 5'b101_11: begin
        q.push_back(ov(0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        q.push_back(ov(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        q.push_back(ov(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      end
      5'b101_00, 5'b101_10: begin
        q.push_back(ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        q.push_back(ov(0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        q.push_back(ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        q.push_back(ov(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      end
      5'b101_01: begin
        q.push_back(ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        q.push_back(ov(0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        q.push_back(ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        halted = 1'b1;
`endif
      end
    endcase
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      halted = 1'b0;
    end else if (q.size() != 0) begin
      void'(q.pop_front());
    end else if (!halted && s) begin
      start({opcode, op});
    end
  end

  function automatic logic [13:0] expv();
    if (q.size() != 0) return q[0];
    if (halted) return ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    return ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  wire [13:0] dutv = {w, nsel, vsel, write, loada, loadb, loadc,
                      loads, asel, bsel, err};

  always @(negedge clk) begin
    checks++;
    if (dutv !== expv()) begin
      errors++;
      $display("FAIL outputs t=%0t got %b want %b", $time, dutv, expv());
    end
    checks++;
    if ((write && loadc) || ($countones({loada, loadb, loadc, loads}) > 1)) begin
      errors++;
      $display("FAIL strobe_excl t=%0t got %b want exclusive", $time, dutv);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // opcode/op scrambled right after capture to prove ins_q is used
  task automatic run_ins(input logic [4:0] ins, output int l);
    @(negedge clk);
    {opcode, op} = ins;
    s = 1'b1;
    @(negedge clk);
    s = 1'b0;
    {opcode, op} = 5'b000_00;
    l = 1;
    while (w !== 1'b1 && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  initial begin
    reset = 1'b0;
    s = 1'b0;
    opcode = 3'b000;
    op = 2'b00;
    #1;
    chk("reset_w", int'(w), 1);
    chk("reset_err", int'(err), 0);
    chk("reset_strobes", int'({write, loada, loadb, loadc, loads}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_ins(5'b110_10, lat); chk("lat_mov_imm", lat, 3);
    run_ins(5'b101_00, lat); chk("lat_add", lat, 6);
    run_ins(5'b101_01, lat); chk("lat_cmp", lat, 5);
    run_ins(5'b110_00, lat); chk("lat_mov_reg", lat, 5);
    run_ins(5'b101_11, lat); chk("lat_mvn", lat, 5);
    run_ins(5'b101_10, lat); chk("lat_and", lat, 6);
`ifndef CTRL_ILLEGAL_TRAP_EN
    run_ins(5'b111_00, lat); chk("lat_illegal", lat, 2);
`endif

    @(negedge clk);
    {opcode, op} = 5'b110_10;
    s = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(w);
    end
    s = 1'b0;
    repeat (3) @(negedge clk);
    chk("w_pulses", cnt, 2);

    @(negedge clk);
    {opcode, op} = 5'b101_00;
    s = 1'b1;
    @(negedge clk);
    s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("exec_loadc", int'(loadc), 1);
    #1 reset = 1'b0;
    #1;
    chk("abort_w", int'(w), 1);
    chk("abort_strobes", int'({write, loada, loadb, loadc, loads}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_after_reset", int'(w), 1);

`ifdef CTRL_ILLEGAL_TRAP_EN
    @(negedge clk);
    {opcode, op} = 5'b111_00;
    s = 1'b1;
    @(negedge clk);
    s = 1'b0;
    repeat (10) begin
      @(negedge clk);
      s = ~s;
    end
    s = 1'b0;
    chk("halt_err", int'(err), 1);
    chk("halt_w", int'(w), 0);
    #2 reset = 1'b0;
    #1;
    chk("halt_clr_err", int'(err), 0);
    chk("halt_clr_w", int'(w), 1);
    @(negedge clk);
    reset = 1'b1;
    run_ins(5'b110_10, lat); chk("lat_after_halt", lat, 3);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Moore FSM that sequences the lab6 datapath (register file, A/B/C pipeline registers, shifter, ALU, status) for one instruction at a time.
- Takes the decoded opcode/op fields from the instruction decoder.
- Drives nsel back into the decoder, plus every datapath load/select strobe.
- Handshakes with the top level via start `s` and waiting flag `w`.

Parameters:
none (all encodings are fixed constants in the shared package)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
s  input  1  start; sampled only in WAIT
opcode  input  3  instruction bits [15:13] from decoder
op  input  2  instruction bits [12:11] from decoder
w  output  1  high while in WAIT (idle, ready for s)
nsel  output  2  register select to decoder: 00=Rn, 01=Rd, 10=Rm
vsel  output  2  writeback mux: 00=C, 01=PC, 10=sximm8, 11=mdata
write  output  1  register-file write enable
loada  output  1  load A register
loadb  output  1  load B register
loadc  output  1  load C register
loads  output  1  load status register
asel  output  1  1 = A operand forced to 0
bsel  output  1  1 = B operand is sximm5
err  output  1  illegal-instruction flag (see Optional Feature)

Behaviour:
Outputs and reset
- All outputs are a pure function of the state register plus ins_q; no input-to-output combinational path.
- Any output not listed for a state is 0.
- Reset low → state=WAIT immediately, asynchronously.
- During reset: w=1, nsel=00, vsel=00, ins_q=0, all strobes 0, err=0.
- Reset mid-instruction aborts it; no partial write occurs after the reset edge.

Instruction capture
- ins_q[4:0] is loaded with {opcode,op} on the edge leaving WAIT (s=1).
- All later branching uses ins_q, so opcode/op may change after that edge.

States and outputs
- WAIT: w=1. s=1 → DECODE; else stay.
- DECODE: no strobes. Branch on ins_q:
  - 110_10 (MOV imm) → WRIMM
  - 110_00 (MOV reg) → GETB
  - 101_11 (MVN) → GETB
  - 101_00/01/10 (ADD/CMP/AND) → GETA
  - others → illegal handling
- WRIMM: nsel=00, vsel=10, write=1 → WAIT.
- GETA: nsel=00, loada=1 → GETB.
- GETB: nsel=10, loadb=1 → CMP ? STAT : EXEC.
- EXEC: loadc=1, bsel=0, asel=1 for MOV reg/MVN, else asel=0 → WRREG.
- STAT: loads=1, asel=0, bsel=0 → WAIT.
- WRREG: nsel=01, vsel=00, write=1 → WAIT.

Latency (edges from s sampled in WAIT back to WAIT)
- MOV imm: 3
- MOV reg / MVN: 5
- CMP: 5
- ADD / AND: 6

Boundary conditions
- s is ignored outside WAIT.
- s held high continuously starts the next instruction on the first WAIT cycle; w pulses high for exactly one cycle between instructions.
- write and loadc are never asserted in the same state; at most one of loada/loadb/loadc/loads is high per cycle.
- Illegal ins_q without the macro: DECODE → WAIT (behaves as NOP, 2 cycles), err stays 0.

Optional Feature:
Macro CTRL_ILLEGAL_TRAP_EN.

Defined:
- Illegal ins_q: DECODE → HALT.
- HALT: err=1, w=0, no strobes, s ignored; exits only via reset.

Undefined:
- HALT state not compiled; illegal instructions are NOPs as above.
- err is tied to 0.

Decomposition:
Package cpu_ctrl_pkg holds:
- state_t enum: WAIT, DECODE, WRIMM, GETA, GETB, EXEC, STAT, WRREG, HALT
- NSEL_RN/RD/RM constants
- VSEL_C/PC/IMM8/MDATA constants
- 5-bit {opcode,op} constants: MOV_IMM, MOV_REG, ADD, CMP, AND, MVN

Structure:
- One always_ff for state and ins_q.
- One always_comb for next-state and outputs.
- No sub-module warranted; the output decode is too small to split out.

Test Plan:
1. Assert reset=0 mid-EXEC of ADD → same cycle: state=WAIT, w=1, all strobes 0. Release reset → remains WAIT until s.
2. MOV imm: s=1, {opcode,op}=110_10 → after 2 edges, one cycle of nsel=00, vsel=10, write=1; w=1 on the 3rd edge.
3. ADD: {opcode,op}=101_00 → strobe order loada(nsel=00), loadb(nsel=10), loadc(asel=0), write(nsel=01, vsel=00); w returns after 6 edges.
4. CMP: {opcode,op}=101_01 → loada, loadb, loads; write never asserted; 5 edges.
5. MOV reg / MVN (110_00, 101_11): no loada, EXEC has asel=1. Also change opcode to 000 right after DECODE → sequence unaffected (ins_q latched).
6. Illegal {opcode,op}=111_00:
   - Without macro: w back after 2 edges, err=0.
   - With CTRL_ILLEGAL_TRAP_EN: err=1 and w=0 hold through 10 cycles with s pulsed; reset clears both.
